// File: rtl/vu_pkg.sv
// vu_pkg: shared state encoding, channel constants and defaults for the VU meter blocks.
package vu_pkg;
  localparam int DATA_W_DEFAULT = 10;
  localparam logic CH_LEFT = 1'b0;
  localparam logic CH_RIGHT = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_PUBLISH} state_t;
endpackage

// File: rtl/vu_tick_div.sv
// vu_tick_div: enable-gated divider producing a one-cycle tick every DIV cycles.
module vu_tick_div #(
  parameter int DIV_W = 16,
  parameter int DIV = 1000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = enable && cnt == DIV_W'(DIV - 1);
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (!enable || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/vu_adc_sequencer.sv
// vu_adc_sequencer: schedules left/right ADC conversions per sample tick and publishes the pair.
module vu_adc_sequencer
  import vu_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int SAMPLE_DIV = 1000,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_err,
  output logic              adc_start,
  output logic              adc_ch,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] left_level,
  output logic [DATA_W-1:0] right_level,
  output logic              level_valid,
  output logic              timeout_err,
  output logic              overrun_err
);
  state_t state, state_n;
  logic tick, done_ok, timed_out, adv;
  logic [7:0] wd;
  vu_tick_div #(.DIV_W(DIV_W), .DIV(SAMPLE_DIV)) u_div (
    .clk_in(clk_in),
    .reset(reset),
    .enable(enable),
    .tick(tick)
  );
  assign done_ok = state == S_WAIT && adc_done;
  // a done in the watchdog-limit cycle takes priority over the abort
  assign timed_out = state == S_WAIT && !adc_done && wd == 8'(TIMEOUT);
  assign adv = done_ok || timed_out;
  always_comb begin
    adc_start = state == S_START;
    level_valid = state == S_PUBLISH;
    state_n = state == S_IDLE  ? (tick ? S_START : S_IDLE) :
              state == S_START ? S_WAIT :
              state == S_WAIT  ? (adv ? (adc_ch == CH_LEFT ? S_START : S_PUBLISH) : S_WAIT) :
              S_IDLE;
  end
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      adc_ch <= CH_LEFT;
      wd <= '0;
      left_level <= '0;
      right_level <= '0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state <= state_n;
      adc_ch <= (state == S_IDLE && tick) ? CH_LEFT : (adv && adc_ch == CH_LEFT) ? CH_RIGHT : adc_ch;
      wd <= state == S_START ? '0 : state == S_WAIT ? wd + 8'd1 : wd;
      if (done_ok && adc_ch == CH_LEFT) left_level <= adc_data;
      if (done_ok && adc_ch == CH_RIGHT) right_level <= adc_data;
      timeout_err <= timed_out || (timeout_err && !clear_err);
      overrun_err <= (tick && state != S_IDLE) || (overrun_err && !clear_err);
    end
endmodule

// File: tb/tb_vu_adc_sequencer.sv
// tb_vu_adc_sequencer: schedule-based reference model with per-cycle compare and directed phases.
module tb_vu_adc_sequencer;
  localparam int DIV = 10, T = 8, W = 10;
  logic clk_in = 0, reset = 1, enable = 0, clear_err = 0, adc_done = 0;
  logic [W-1:0] adc_data = '0;
  logic adc_start, adc_ch, level_valid, timeout_err, overrun_err;
  logic [W-1:0] left_level, right_level;

  vu_adc_sequencer #(.DIV_W(16), .SAMPLE_DIV(DIV), .DATA_W(W), .TIMEOUT(T)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .clear_err(clear_err),
    .adc_start(adc_start), .adc_ch(adc_ch), .adc_done(adc_done), .adc_data(adc_data),
    .left_level(left_level), .right_level(right_level), .level_valid(level_valid),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0, n_err = 0;
  task automatic chk(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_start"}, adc_start, 0);
    chk({tag, "_ch"}, adc_ch, 0);
    chk({tag, "_valid"}, level_valid, 0);
    chk({tag, "_left"}, left_level, 0);
    chk({tag, "_right"}, right_level, 0);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_oerr"}, overrun_err, 0);
  endtask

  // scenario knobs, written by the script on rising edges, read by the model on falling edges
  bit en_k = 0, spur_k = 0, rnd_clr_k = 0, rnd_en_k = 0, rnd_data_k = 0;
  int l_lo = 3, l_hi = 3, r_lo = 3, r_hi = 3;
  int clr_req = 0, clr_ack = 0;
  logic [W-1:0] dl = 10'h155, dr = 10'h2AA;

  // model: one sequence described by absolute cycle numbers of its events
  longint cyc = 0, s0, e0, s1, e1, p;
  int run = 0;
  bit act = 0, ok0, ok1;
  logic [W-1:0] d0, d1, m_lv = '0, m_rv = '0;
  bit m_ch = 0, m_te = 0, m_oe = 0;

  always @(negedge clk_in) begin : mdl
    bit tick, idle, st_t, in_wait, dn;
    logic [W-1:0] dd;
    int l;
    cyc++;
    if (!reset) begin
      act = 0; run = 0; m_ch = 0; m_lv = '0; m_rv = '0; m_te = 0; m_oe = 0;
    end
    chk("adc_start", adc_start, int'(act && (cyc == s0 || cyc == s1)));
    chk("level_valid", level_valid, int'(act && cyc == p));
    chk("adc_ch", adc_ch, m_ch);
    chk("left_level", left_level, m_lv);
    chk("right_level", right_level, m_rv);
    chk("timeout_err", timeout_err, m_te);
    chk("overrun_err", overrun_err, m_oe);
    if (!reset) begin
      enable = 0; clear_err = 0; adc_done = 0;
    end else begin
      enable = rnd_en_k ? ($urandom_range(39, 0) == 0 ? !enable : enable) : en_k;
      clear_err = (clr_req != clr_ack) || (rnd_clr_k && $urandom_range(31, 0) == 0);
      clr_ack = clr_req;
      in_wait = act && ((cyc > s0 && cyc <= e0) || (cyc > s1 && cyc <= e1));
      dn = act && ((cyc == e0 && ok0) || (cyc == e1 && ok1));
      dd = (act && cyc == e0) ? d0 : d1;
      if (!in_wait && spur_k && $urandom_range(7, 0) == 0) begin
        dn = 1; dd = W'($urandom);
      end
      adc_done = dn;
      adc_data = dn ? dd : W'($urandom);
      tick = enable && (run % DIV == DIV - 1);
      run = enable ? run + 1 : 0;
      idle = !(act && cyc >= s0 && cyc <= p);
      st_t = act && ((cyc == e0 && !ok0) || (cyc == e1 && !ok1));
      m_te = st_t || (m_te && !clear_err);
      m_oe = (tick && !idle) || (m_oe && !clear_err);
      if (act && cyc == e0 && ok0) m_lv = d0;
      if (act && cyc == e1 && ok1) m_rv = d1;
      if (act && cyc == e0) m_ch = 1;
      if (act && cyc == p) act = 0;
      if (tick && idle) begin
        act = 1; m_ch = 0; s0 = cyc + 1;
        l = $urandom_range(l_hi, l_lo); ok0 = l <= T + 1;
        e0 = s0 + (ok0 ? l : T + 1); s1 = e0 + 1;
        l = $urandom_range(r_hi, r_lo); ok1 = l <= T + 1;
        e1 = s1 + (ok1 ? l : T + 1); p = e1 + 1;
        d0 = rnd_data_k ? W'($urandom) : dl;
        d1 = rnd_data_k ? W'($urandom) : dr;
      end
    end
  end

  int vcnt, scnt;
  task automatic count(input int n, output int v, output int s);
    v = 0; s = 0;
    repeat (n) begin
      @(posedge clk_in); #1;
      v += int'(level_valid);
      s += int'(adc_start);
    end
  endtask

  initial begin
    bit found;
    #3 reset = 0;
    #1 chk_zero("rst");
    repeat (3) @(posedge clk_in);
    #3 reset = 1;
    en_k = 1;
    repeat (20) @(posedge clk_in);
    count(40, vcnt, scnt);
    chk("pair_rate", vcnt, 4);
    chk("pair_starts", scnt, 8);
    chk("pair_left", left_level, 'h155);
    chk("pair_right", right_level, 'h2AA);
    chk("pair_terr", timeout_err, 0);
    r_lo = T + 2; r_hi = T + 2;
    count(40, vcnt, scnt);
    chk("to_err", timeout_err, 1);
    chk("to_keep_right", right_level, 'h2AA);
    chk("to_valid", int'(vcnt >= 2), 1);
    r_lo = 3; r_hi = 3;
    repeat (30) @(posedge clk_in);
    clr_req++;
    @(posedge clk_in); @(posedge clk_in); #1;
    chk("clr_terr", timeout_err, 0);
    chk("clr_oerr", overrun_err, 0);
    l_lo = 5; l_hi = 5; r_lo = 5; r_hi = 5;
    repeat (20) @(posedge clk_in);
    count(40, vcnt, scnt);
    chk("ovr_err", overrun_err, 1);
    chk("ovr_valid", vcnt, 2);
    chk("ovr_starts", scnt, 4);
    l_lo = 3; l_hi = 3; r_lo = 3; r_hi = 3;
    clr_req++;
    repeat (25) @(posedge clk_in);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk_in); #1;
      found = adc_start && !adc_ch;
    end
    chk("en_left_start", found, 1);
    @(posedge clk_in);
    en_k = 0;
    count(30, vcnt, scnt);
    chk("en_valid", vcnt, 1);
    chk("en_starts", scnt, 1);
    clr_req++;
    l_lo = T + 1; l_hi = T + 1; dl = 10'h0F0;
    en_k = 1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk_in); #1;
      found = level_valid;
    end
    chk("race_valid", found, 1);
    chk("race_left", left_level, 'h0F0);
    chk("race_terr", timeout_err, 0);
    rnd_data_k = 1; spur_k = 1; rnd_clr_k = 1; rnd_en_k = 1;
    l_lo = 1; l_hi = T + 3; r_lo = 1; r_hi = T + 3;
    repeat (1500) @(posedge clk_in);
    #3 reset = 0;
    #1 chk_zero("mrst");
    repeat (2) @(posedge clk_in);
    #3 reset = 1;
    repeat (1500) @(posedge clk_in);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
